// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: registered read data, lane-enabled writes, WAIT_STATES stall cycles per OKAY data phase.
// Define AHB_SLV_ERR_CHK_EN to answer out-of-range, oversize or misaligned transfers with a two-cycle ERROR.
module ahb_slave_mem #(
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [6:0]  hprot,
  input  logic        hexcl,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic        hexokay
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] ph_idx;
  logic          ph_write;
  logic [3:0]    ph_be;
  logic [31:0]   mem [MEM_DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          accept;
  logic          legal;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   rd_word;

  assign off     = haddr - BASE_ADDR;
  assign idx     = off[AW+1:2];
  assign accept  = hsel & hready & htrans[1];
  assign commit  = (state == S_DATA) && ph_write;
  assign hexokay = 1'b0;

`ifdef AHB_SLV_ERR_CHK_EN
  assign legal = (off[31:AW+2] == '0) && (hsize <= 3'b010) &&
                 !(hsize == 3'b001 && haddr[0]) &&
                 !(hsize == 3'b010 && haddr[1:0] != 2'b00);
`else
  assign legal = 1'b1;
`endif

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hexcl, off[31:AW+2], off[1:0]};

  always_comb begin
    be = 4'b1111;
    case (hsize)
      3'b000:  be = 4'b0001 << haddr[1:0];
      3'b001:  be = haddr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // A write finishing on the same edge a read of that word is accepted must be visible in the read.
  always_comb begin
    rd_word = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (commit && ph_idx == idx && ph_be[i]) rd_word[i*8 +: 8] = hwdata[i*8 +: 8];
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (ph_be[i]) mem[ph_idx][i*8 +: 8] <= hwdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 2'b00;
      hrdata    <= 32'h0;
      cnt       <= 4'h0;
      ph_idx    <= '0;
      ph_write  <= 1'b0;
      ph_be     <= 4'h0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 4'h0) begin
            state     <= S_DATA;
            hreadyout <= 1'b1;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 2'b01;
        end
        default: begin
          // IDLE, DATA and ERR2 all present hreadyout=1, so a new address phase may land here.
          ph_write <= 1'b0;
          if (accept && legal) begin
            ph_idx   <= idx;
            ph_write <= hwrite;
            ph_be    <= be;
            hresp    <= 2'b00;
            if (!hwrite) hrdata <= rd_word;
            if (WAIT_STATES > 0) begin
              state     <= S_WAIT;
              hreadyout <= 1'b0;
              cnt       <= 4'(WAIT_STATES - 1);
            end else begin
              state     <= S_DATA;
              hreadyout <= 1'b1;
            end
          end else if (accept) begin
            state     <= S_ERR1;
            hreadyout <= 1'b0;
            hresp     <= 2'b01;
          end else begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one zero-wait and one three-wait instance driven by a pipelined AHB master,
// checked against a byte-lane memory model.
module tb_ahb_slave_mem;

  localparam int DEPTH = 64;
  localparam logic [31:0] BASE = 32'h0;

  typedef struct {
    logic        idle;
    logic        wr;
    logic        seq;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;
  logic hrst;

  logic        hsel_a[2];
  logic [31:0] haddr_a[2];
  logic [1:0]  htrans_a[2];
  logic        hwrite_a[2];
  logic [2:0]  hsize_a[2];
  logic [2:0]  hburst_a[2];
  logic [6:0]  hprot_a[2];
  logic        hexcl_a[2];
  logic [31:0] hwdata_a[2];
  logic [31:0] hrdata_a[2];
  logic        hreadyout_a[2];
  logic [1:0]  hresp_a[2];
  logic        hexokay_a[2];

  ahb_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel_a[0]), .haddr(haddr_a[0]), .htrans(htrans_a[0]),
    .hwrite(hwrite_a[0]), .hsize(hsize_a[0]), .hburst(hburst_a[0]), .hprot(hprot_a[0]),
    .hexcl(hexcl_a[0]), .hwdata(hwdata_a[0]), .hready(hreadyout_a[0]), .hrdata(hrdata_a[0]),
    .hreadyout(hreadyout_a[0]), .hresp(hresp_a[0]), .hexokay(hexokay_a[0]));

  ahb_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel_a[1]), .haddr(haddr_a[1]), .htrans(htrans_a[1]),
    .hwrite(hwrite_a[1]), .hsize(hsize_a[1]), .hburst(hburst_a[1]), .hprot(hprot_a[1]),
    .hexcl(hexcl_a[1]), .hwdata(hwdata_a[1]), .hready(hreadyout_a[1]), .hrdata(hrdata_a[1]),
    .hreadyout(hreadyout_a[1]), .hresp(hresp_a[1]), .hexokay(hexokay_a[1]));

  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] last_rd;
  xfer_t       q[$];
  int          ws_of[2] = '{0, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % DEPTH);
  endfunction

  function automatic logic illegal(input logic [31:0] a, input logic [2:0] s);
    logic bad;
    bad = ((a - BASE) >= 32'(4 * DEPTH)) || (s > 3'd2) ||
          (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
`ifndef AHB_SLV_ERR_CHK_EN
    bad = 1'b0;
`endif
    return bad;
  endfunction

  // Bytes covered: 1, 2 or 4 (anything wider behaves as a word), aligned down to the access size.
  task automatic model_write(input int d, input xfer_t x);
    int nb, lane0, i;
    nb    = (x.size >= 3'd2) ? 4 : (1 << x.size);
    lane0 = int'(x.addr[1:0]) & ~(nb - 1) & 3;
    i     = widx(x.addr);
    for (int b = lane0; b < lane0 + nb; b++) mem_m[d][i][b*8 +: 8] = x.wdata[b*8 +: 8];
  endtask

  task automatic drive_idle(input int d);
    int r;
    r = $urandom_range(0, 2);
    hsel_a[d]   = (r != 2);
    htrans_a[d] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
    haddr_a[d]  = $urandom;
    hwrite_a[d] = $urandom;
    hsize_a[d]  = 3'd2;
  endtask

  task automatic drive_addr(input int d, input xfer_t x);
    hsel_a[d]   = 1'b1;
    haddr_a[d]  = x.addr;
    htrans_a[d] = x.seq ? 2'b11 : 2'b10;
    hwrite_a[d] = x.wr;
    hsize_a[d]  = x.size;
    hburst_a[d] = $urandom;
    hprot_a[d]  = $urandom;
    hexcl_a[d]  = $urandom;
  endtask

  // Pipelined master: the next address phase is driven during the last cycle of the current data phase.
  task automatic run_q(input int d, output int dcyc);
    xfer_t dp, nx;
    bit dpv, dp_err, was_idle;
    int waits, guard;
    logic [31:0] exp_rd;
    dpv = 0; dp_err = 0; waits = 0; guard = 0; dcyc = 0; exp_rd = '0;
    while ((q.size() > 0 || dpv) && guard < 20000) begin
      @(negedge hclk);
      guard++;
      was_idle = !dpv;
      if (was_idle) chk($sformatf("d%0d idle_rdy_resp", d), {29'b0, hreadyout_a[d], hresp_a[d]}, 32'h4);
      if (dpv) begin
        dcyc++;
        hwdata_a[d] = dp.wdata;
        if (!hreadyout_a[d]) begin
          waits++;
          if (dp_err) chk($sformatf("d%0d err1_resp", d), hresp_a[d], 2'b01);
          else begin
            chk($sformatf("d%0d wait_resp", d), hresp_a[d], 2'b00);
            if (!dp.wr) chk($sformatf("d%0d rd_stable", d), hrdata_a[d], exp_rd);
          end
        end else begin
          chk($sformatf("d%0d wait_count", d), waits, dp_err ? 1 : ws_of[d]);
          chk($sformatf("d%0d final_resp", d), hresp_a[d], dp_err ? 2'b01 : 2'b00);
          chk($sformatf("d%0d hexokay", d), hexokay_a[d], 0);
          if (!dp_err) begin
            if (dp.wr) model_write(d, dp);
            else begin
              chk($sformatf("d%0d rdata @%h", d, dp.addr), hrdata_a[d], exp_rd);
              last_rd = hrdata_a[d];
            end
          end
          dpv = 0;
        end
      end
      if (!dpv) begin
        if (q.size() > 0) begin
          nx = q.pop_front();
          if (nx.idle) drive_idle(d);
          else begin
            drive_addr(d, nx);
            dp = nx; dpv = 1; waits = 0;
            dp_err = illegal(nx.addr, nx.size);
            exp_rd = mem_m[d][widx(nx.addr)];
          end
        end else drive_idle(d);
      end
    end
    chk($sformatf("d%0d drained", d), q.size() + int'(dpv), 0);
    q.delete();
  endtask

  function automatic xfer_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] w);
    xfer_t x;
    x.idle = 0; x.wr = wr; x.seq = 0; x.addr = a; x.size = s; x.wdata = w;
    return x;
  endfunction

  function automatic xfer_t rnd();
    xfer_t x;
    int nb;
    x.idle  = ($urandom_range(0, 3) == 0);
    x.wr    = $urandom;
    x.seq   = $urandom;
    x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    x.wdata = $urandom;
    nb      = (x.size >= 3'd2) ? 4 : (1 << x.size);
    x.addr  = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    if ($urandom_range(0, 7) != 0) x.addr = x.addr & ~32'(nb - 1);
    if ($urandom_range(0, 9) == 0) x.addr = x.addr + 32'(4 * DEPTH);
    return x;
  endfunction

  initial begin
    int dc;
    xfer_t x;
    for (int d = 0; d < 2; d++) begin
      hsel_a[d] = 0; haddr_a[d] = 0; htrans_a[d] = 0; hwrite_a[d] = 0; hsize_a[d] = 0;
      hburst_a[d] = 0; hprot_a[d] = 0; hexcl_a[d] = 0; hwdata_a[d] = 0;
    end
    last_rd = 0;
    hrst = 1'b0;
    repeat (2) @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst_hreadyout", d), hreadyout_a[d], 1);
      chk($sformatf("d%0d rst_hresp", d), hresp_a[d], 0);
      chk($sformatf("d%0d rst_hrdata", d), hrdata_a[d], 0);
      chk($sformatf("d%0d rst_hexokay", d), hexokay_a[d], 0);
    end
    hrst = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) q.push_back(mk(1, BASE + 32'(4 * i), 3'd2, $urandom));
      run_q(d, dc);
    end

    q.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF));
    q.push_back(mk(0, 32'h10, 3'd2, 32'h0));
    run_q(0, dc);
    chk("fwd_read", last_rd, 32'hDEADBEEF);
    chk("fwd_cycles", dc, 2);

    q.push_back(mk(1, 32'h88, 3'd2, 32'h11223344));
    q.push_back(mk(1, 32'h8A, 3'd0, 32'hA55AC3E1));
    q.push_back(mk(0, 32'h88, 3'd2, 32'h0));
    run_q(0, dc);
    chk("byte_lane", last_rd, 32'h115A3344);

    for (int i = 0; i < 4; i++) begin
      x = mk(0, 32'(4 * i), 3'd2, 32'h0);
      x.seq = (i != 0);
      q.push_back(x);
    end
    run_q(1, dc);
    chk("incr4_cycles", dc, 16);

`ifdef AHB_SLV_ERR_CHK_EN
    for (int d = 0; d < 2; d++) begin
      q.push_back(mk(1, 32'h0, 3'd2, 32'h13572468));
      q.push_back(mk(1, 32'h2, 3'd2, 32'hFFFFFFFF));
      q.push_back(mk(0, 32'h0, 3'd2, 32'h0));
      run_q(d, dc);
      chk($sformatf("d%0d err_no_write", d), last_rd, 32'h13572468);
    end
`endif

    q.push_back(mk(1, 32'h40, 3'd2, 32'hCAFE0001));
    run_q(1, dc);
    @(negedge hclk);
    drive_addr(1, mk(1, 32'h40, 3'd2, 32'h0));
    @(negedge hclk);
    chk("rst_mid_waiting", hreadyout_a[1], 0);
    hsel_a[1] = 0; htrans_a[1] = 2'b00; hwdata_a[1] = 32'h0BAD0BAD;
    hrst = 1'b0;
    @(negedge hclk);
    hrst = 1'b1;
    chk("rst_mid_hreadyout", hreadyout_a[1], 1);
    chk("rst_mid_hresp", hresp_a[1], 0);
    q.push_back(mk(0, 32'h40, 3'd2, 32'h0));
    run_q(1, dc);
    chk("rst_mid_old_data", last_rd, 32'hCAFE0001);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 300; i++) q.push_back(rnd());
      run_q(d, dc);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
